// File: rtl/s27_pkg.sv
// s27_pkg: shared state type, LFSR taps and default seed for the s27 stimulus generator
package s27_pkg;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;
  localparam logic [3:0] LFSR_TAPS = 4'b1100;
  localparam logic [3:0] SEED_DEF = 4'b1001;
  function automatic logic [3:0] lfsr_next(input logic [3:0] q);
    return {q[2:0], ^(q & LFSR_TAPS)};
  endfunction
endpackage

// File: rtl/s27_lfsr4.sv
// s27_lfsr4: 4-bit Fibonacci LFSR (x^4+x^3+1) shifting toward bit 3
module s27_lfsr4 import s27_pkg::*; #(
  parameter logic [3:0] SEED = SEED_DEF
) (
  input  logic       clk_net,
  input  logic       reset_net,
  input  logic       load,
  input  logic       en,
  input  logic [3:0] seed,
  output logic [3:0] q
);
  logic [3:0] r_q;
  // load the seed on run entry, otherwise step once per launched vector
  always_ff @(posedge clk_net or posedge reset_net)
    if (reset_net) r_q <= SEED;
    else if (load) r_q <= seed;
    else if (en) r_q <= lfsr_next(r_q);
  assign q = r_q;
endmodule

// File: rtl/s27_stim_gen.sv
// s27_stim_gen: drives LFSR vectors into an s27 netlist and checks G17 against a fixed expectation
module s27_stim_gen import s27_pkg::*; #(
  parameter int         N_VEC = 16,
  parameter int         LAT   = 2,
  parameter logic [3:0] SEED  = SEED_DEF,
  parameter logic       EXP   = 1'b0
) (
  input  logic       clk_net,
  input  logic       reset_net,
  input  logic       start,
  output logic       G0,
  output logic       G1,
  output logic       G2,
  output logic       G3,
  input  logic       G17,
  output logic       busy,
  output logic       done,
  output logic [7:0] err_cnt,
  output logic       pass
);
  state_t r_state, w_next;
  logic [3:0] w_lfsr, r_g;
  logic [7:0] r_cnt, r_err, w_err_nxt;
  logic [LAT-1:0] r_vsr, w_vsr_nxt;
  logic r_pass, w_load, w_launch, w_sample, w_last;
  s27_lfsr4 #(.SEED(SEED)) u_lfsr (
    .clk_net(clk_net),
    .reset_net(reset_net),
    .load(w_load),
    .en(w_launch),
    .seed(SEED),
    .q(w_lfsr)
  );
  assign w_last = r_cnt == 8'(N_VEC - 1);
  assign w_vsr_nxt = LAT'({r_vsr, w_launch});
  assign w_sample = r_vsr[LAT-1];
  assign w_err_nxt = (w_sample && G17 != EXP && r_err != 8'hff) ? r_err + 8'd1 : r_err;
  // state register
  always_ff @(posedge clk_net or posedge reset_net)
    if (reset_net) r_state <= S_IDLE;
    else r_state <= w_next;
  // next state: leave DRAIN once the last in-flight tag has been sampled
  always_comb
    case (r_state)
      S_IDLE:  w_next = start ? S_RUN : S_IDLE;
      S_RUN:   w_next = w_last ? S_DRAIN : S_RUN;
      S_DRAIN: w_next = w_vsr_nxt == '0 ? S_DONE : S_DRAIN;
      default: w_next = S_IDLE;
    endcase
  // state decoded controls and status
  always_comb begin
    w_load = r_state == S_IDLE && start;
    w_launch = r_state == S_RUN;
    busy = r_state == S_RUN || r_state == S_DRAIN;
    done = r_state == S_DONE;
  end
  // vector register, launch counter, latency tags, error count and verdict
  always_ff @(posedge clk_net or posedge reset_net)
    if (reset_net) begin
      r_g <= '0;
      r_cnt <= '0;
      r_vsr <= '0;
      r_err <= '0;
      r_pass <= 1'b0;
    end else begin
      r_g <= w_launch ? w_lfsr : 4'b0000;
      r_cnt <= w_load ? 8'd0 : w_launch ? r_cnt + 8'd1 : r_cnt;
      r_vsr <= w_vsr_nxt;
      r_err <= w_load ? 8'd0 : w_err_nxt;
      r_pass <= w_load ? 1'b0 : (r_state == S_DRAIN && w_next == S_DONE) ? w_err_nxt == 8'd0 : r_pass;
    end
  assign {G3, G2, G1, G0} = r_g;
  assign err_cnt = r_err;
  assign pass = r_pass;
endmodule
